// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage RV32I core: hazard detection, E-stage forwarding,
// multi-cycle stall FSM (memory wait / mul-div busy) and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             MdStartE,
  input  logic             MdDoneE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemErr
);

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              lw_stall;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [1:0]        fwd_a, fwd_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + {{(WAIT_W-1){1'b0}}, 1'b1};
  endfunction

  // M result is younger than W, so it wins when both match
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a    = fwd_sel(Rs1E);
  assign fwd_b    = fwd_sel(Rs2E);
  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w   = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (MdStartE && !MdDoneE) begin
          {stall_f, stall_d, stall_e} = 3'b111;
          flush_m   = 1'b1;
          state_nxt = MD_BUSY;
        end else begin
          stall_f = lw_stall;
          stall_d = lw_stall;
          flush_d = PCSrcE;
          flush_e = lw_stall | PCSrcE;
        end
      end
      MEM_WAIT: begin
        // E is frozen here, so branch and load-use are only honoured on release
        if (!MemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
        end else begin
          stall_f   = lw_stall;
          stall_d   = lw_stall;
          flush_d   = PCSrcE;
          flush_e   = lw_stall | PCSrcE;
          state_nxt = RUN;
        end
      end
      MD_BUSY: begin
        if (!MdDoneE) begin
          {stall_f, stall_d, stall_e} = 3'b111;
          flush_m = 1'b1;
        end else begin
          stall_f   = lw_stall;
          stall_d   = lw_stall;
          flush_d   = PCSrcE;
          flush_e   = lw_stall | PCSrcE;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Wait counter counts stalled memory cycles, including the one that detected the miss
  always_comb begin
    wait_cnt_nxt = '0;
    if (state_nxt == MEM_WAIT) begin
      if (state == RUN) wait_cnt_nxt = {{(WAIT_W-1){1'b0}}, 1'b1};
      else              wait_cnt_nxt = sat_inc_wait(wait_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if ((state_nxt == MEM_WAIT) && (wait_cnt_nxt >= TIMEOUT_V))
        MemErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_f)
        StallCount <= sat_inc(StallCount);
      if (flush_d || flush_e)
        FlushCount <= sat_inc(FlushCount);
    end
  end

  // Outputs are held inactive for as long as reset is asserted
  assign StallF    = stall_f & reset;
  assign StallD    = stall_d & reset;
  assign StallE    = stall_e & reset;
  assign StallM    = stall_m & reset;
  assign FlushD    = flush_d & reset;
  assign FlushE    = flush_e & reset;
  assign FlushM    = flush_m & reset;
  assign FlushW    = flush_w & reset;
  assign ForwardAE = reset ? fwd_a : 2'b00;
  assign ForwardBE = reset ? fwd_b : 2'b00;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, MdStartE, MdDoneE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .FlushCount(FlushCount), .MemErr(MemErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0; MdStartE = 0; MdDoneE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    // hazards present while in reset must not reach the outputs
    LoadE = 1; RdE = 5; Rs1D = 5; RegWriteM = 1; RdM = 7; Rs1E = 7; PCSrcE = 1;
    #2;
    chk("rst_stallf", StallF, 0);
    chk("rst_flushe", FlushE, 0);
    chk("rst_flushd", FlushD, 0);
    chk("rst_fwda", ForwardAE, 0);
    chk("rst_scnt", StallCount, 0);
    chk("rst_fcnt", FlushCount, 0);
    chk("rst_memerr", MemErr, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    tick();

    // load-use on Rs1D
    LoadE = 1; RdE = 5; Rs1D = 5; #1;
    chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    chk("lu_flushe", FlushE, 1);
    chk("lu_flushd", FlushD, 0);
    chk("lu_stalle", StallE, 0);
    tick();
    chk("lu_scnt", StallCount, 1);
    chk("lu_fcnt", FlushCount, 1);
    idle(); LoadE = 1; RdE = 0; Rs1D = 0; #1;
    chk("lu_x0_stallf", StallF, 0);
    chk("lu_x0_flushe", FlushE, 0);
    tick();
    chk("lu_x0_scnt", StallCount, 1);
    // load-use on Rs2D
    idle(); LoadE = 1; RdE = 3; Rs2D = 3; Rs1D = 9; #1;
    chk("lu2_stalld", StallD, 1);
    tick();
    chk("lu2_scnt", StallCount, 2);
    chk("lu2_fcnt", FlushCount, 2);

    // forwarding
    idle(); RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7; Rs1E = 7; Rs2E = 0; #1;
    chk("fwd_a_m", ForwardAE, 2'b10);
    chk("fwd_b_x0", ForwardBE, 2'b00);
    RegWriteM = 0; #1;
    chk("fwd_a_w", ForwardAE, 2'b01);
    Rs2E = 7; #1;
    chk("fwd_b_w", ForwardBE, 2'b01);
    RegWriteW = 0; #1;
    chk("fwd_a_none", ForwardAE, 2'b00);

    // branch plus load-use in the same cycle
    idle(); tick();
    PCSrcE = 1; LoadE = 1; RdE = 5; Rs1D = 5; #1;
    chk("bl_stallf", StallF, 1);
    chk("bl_stalld", StallD, 1);
    chk("bl_flushd", FlushD, 1);
    chk("bl_flushe", FlushE, 1);
    tick();
    chk("bl_scnt", StallCount, 3);
    chk("bl_fcnt", FlushCount, 3);
    idle(); PCSrcE = 1; #1;
    chk("br_flushd", FlushD, 1);
    chk("br_stallf", StallF, 0);
    tick();
    chk("br_fcnt", FlushCount, 4);

    // memory wait: 3 stalled cycles, released on ready
    idle(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      PCSrcE = (i == 1); #1;
      chk("mw_stallm", StallM, 1);
      chk("mw_flushw", FlushW, 1);
      chk("mw_stallf", StallF, 1);
      if (i == 1) chk("mw_br_ignored", FlushD, 0);
      tick();
    end
    PCSrcE = 0;
    chk("mw_scnt", StallCount, 6);
    chk("mw_fcnt", FlushCount, 4);
    MemReadyM = 1; #1;
    chk("mw_rel_stallm", StallM, 0);
    chk("mw_rel_flushw", FlushW, 0);
    chk("mw_rel_stallf", StallF, 0);
    tick();
    idle(); #1;
    chk("mw_run_stallm", StallM, 0);
    chk("mw_run_scnt", StallCount, 6);
    chk("mw_memerr", MemErr, 0);

    // mul/div busy for 4 cycles
    MdStartE = 1; MdDoneE = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("md_stalle", StallE, 1);
      chk("md_flushm", FlushM, 1);
      chk("md_stallm", StallM, 0);
      tick();
      MdStartE = 0;
    end
    chk("md_scnt", StallCount, 10);
    MdDoneE = 1; #1;
    chk("md_rel_stalle", StallE, 0);
    chk("md_rel_flushm", FlushM, 0);
    tick();
    idle(); #1;
    chk("md_run_stalle", StallE, 0);
    MdStartE = 1; MdDoneE = 1; #1;
    chk("md_single_stalle", StallE, 0);
    tick();
    idle(); #1;
    chk("md_single_after", StallF, 0);
    chk("md_single_scnt", StallCount, 10);

    // timeout, counter saturation, reset mid-wait
    MemReqM = 1; MemReadyM = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      MemReqM = 0;
      if (i == 3) chk("to_memerr_3", MemErr, 0);
      if (i == 4) chk("to_memerr_4", MemErr, 1);
      if (i == 4) chk("to_scnt_14", StallCount, 14);
    end
    chk("to_scnt_sat", StallCount, 15);
    chk("to_still_wait", StallM, 1);
    chk("to_memerr_sticky", MemErr, 1);
    reset = 1'b0; #1;
    chk("rstw_stallf", StallF, 0);
    chk("rstw_stallm", StallM, 0);
    chk("rstw_flushw", FlushW, 0);
    chk("rstw_memerr", MemErr, 0);
    chk("rstw_scnt", StallCount, 0);
    chk("rstw_fcnt", FlushCount, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    #1;
    chk("rstw_run_stallm", StallM, 0);
    MemReqM = 1; MemReadyM = 1; #1;
    chk("rstw_hit_stallm", StallM, 0);
    tick();
    chk("rstw_hit_scnt", StallCount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core.
- Drives the enable and clear inputs of every inter-stage pipeline register (F/D, D/E, E/M, M/W) and the E-stage forwarding muxes.
- Combines combinational hazard detection with a small FSM for multi-cycle events: data-memory wait states and multiply/divide busy.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the StallCount and FlushCount performance counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before MemErr is set (1..2^16-1).

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-low reset (asserted at 0).
- Rs1D, Rs2D in 5 each: source registers of the instruction in D.
- Rs1E, Rs2E, RdE in 5 each: source and destination registers in E.
- RdM, RdW in 5 each: destination registers in M and W.
- RegWriteM, RegWriteW in 1 each: register-write enables in M and W.
- LoadE in 1: instruction in E is a load.
- PCSrcE in 1: taken branch or jump resolved in E.
- MemReqM in 1: M-stage data-memory access active.
- MemReadyM in 1: data memory completes the access this cycle.
- MdStartE in 1: multi-cycle mul/div instruction present in E.
- MdDoneE in 1: mul/div result valid this cycle.
- StallF, StallD, StallE, StallM out 1 each: hold the stage register (enable = ~Stall).
- FlushD, FlushE, FlushM, FlushW out 1 each: synchronous clear of the stage register.
- ForwardAE, ForwardBE out 2 each: 00 = register file, 01 = W result, 10 = M ALU result.
- StallCount out CNT_W: number of cycles with StallF=1.
- FlushCount out CNT_W: number of cycles with FlushD=1 or FlushE=1.
- MemErr out 1: sticky memory-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, StallCount=0, FlushCount=0, MemErr=0, wait counter=0.
  - While reset=0, all Stall*/Flush* are forced to 0 and Forward*E to 00.
- Forwarding (combinational, state-independent):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules using Rs2E.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Control outputs are Mealy: the state plus current inputs determine them in the same cycle.
- State RUN, evaluated in priority order:
  - 1. MemReqM && !MemReadyM: StallF, StallD, StallE, StallM = 1; FlushW=1; next state MEM_WAIT; wait counter=1.
  - 2. MdStartE && !MdDoneE: StallF, StallD, StallE = 1; FlushM=1; next state MD_BUSY.
  - 3. Otherwise: StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE. Stay in RUN.
  - A taken branch and a load-use stall in the same cycle produce StallF=StallD=1, FlushD=1, FlushE=1.
  - MdStartE && MdDoneE in the same cycle (single-cycle op): no stall.
- State MEM_WAIT:
  - StallF, StallD, StallE, StallM = 1 and FlushW=1 while MemReadyM=0.
  - PCSrcE and lwStall are ignored, because E is frozen.
  - MemReadyM=1: outputs are evaluated as case 3 of RUN, and the next state is RUN.
  - The wait counter increments each cycle in MEM_WAIT. When it reaches MEM_TIMEOUT, MemErr is set. The FSM stays in MEM_WAIT; MemErr clears only on reset.
- State MD_BUSY:
  - StallF, StallD, StallE = 1 and FlushM=1 while MdDoneE=0.
  - MdDoneE=1: outputs are evaluated as case 3 of RUN, and the next state is RUN.
  - A memory miss in M cannot coexist with MD_BUSY, because M holds a bubble.
- Counters:
  - StallCount increments on every cycle with StallF=1.
  - FlushCount increments on every cycle with FlushD=1 or FlushE=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Asserting reset mid-stall returns the FSM to RUN immediately and releases all stalls.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5 in RUN -> StallF=StallD=FlushE=1 for 1 cycle, StallCount=1. Repeat with RdE=0 -> no stall.
- Forwarding: RegWriteM=1, RdM=7, RegWriteW=1, RdW=7, Rs1E=7 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Rs2E=0 -> ForwardBE=00.
- Branch plus load-use in the same cycle: PCSrcE=1, lwStall true -> StallF=StallD=FlushD=FlushE=1, FlushCount increments by 1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/StallD/StallE/StallM and FlushW high for exactly 3 cycles, normal outputs on the 4th, state back to RUN, StallCount=3.
- Mul/div: MdStartE=1, MdDoneE rises 4 cycles later -> StallE and FlushM high for 4 cycles, released in the MdDoneE cycle. Separately, MdStartE=MdDoneE=1 in the same cycle -> no stall.
- Timeout and reset: MEM_TIMEOUT=4 with MemReadyM held 0 -> MemErr=1 after the 4th MEM_WAIT cycle. Drive reset=0 mid-wait -> all stalls 0 immediately, MemErr=0, counters=0, state RUN.
